// File: rtl/ula_nibble_sequencer_if.sv
// Bundle of every signal between ula_nibble_sequencer and the blocks around it:
// the request channel, the result channel and the nibble-wide ALU slice link.
// The slave modport is the sequencer's view. The master modport is the view of
// the requester plus the ula_74181 it drives.
// Define ULA_SEQ_ZERO_FLAG_EN to add the registered zero flag on the result channel.
interface ula_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  // request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_s;
  logic             op_m;
  logic             op_c_in;
  // result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             eq;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic             zero;
`endif
  // ALU slice link
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_c_in;
  logic [3:0]       alu_f;
  logic             alu_c_out;
  logic             alu_a_eq_b;

`ifdef ULA_SEQ_ZERO_FLAG_EN
  modport slave (
    input  in_valid, op_a, op_b, op_s, op_m, op_c_in, out_ready,
    input  alu_f, alu_c_out, alu_a_eq_b,
    output in_ready, out_valid, result, c_out, eq, zero,
    output alu_a, alu_b, alu_s, alu_m, alu_c_in
  );
  modport master (
    output in_valid, op_a, op_b, op_s, op_m, op_c_in, out_ready,
    output alu_f, alu_c_out, alu_a_eq_b,
    input  in_ready, out_valid, result, c_out, eq, zero,
    input  alu_a, alu_b, alu_s, alu_m, alu_c_in
  );
`else
  modport slave (
    input  in_valid, op_a, op_b, op_s, op_m, op_c_in, out_ready,
    input  alu_f, alu_c_out, alu_a_eq_b,
    output in_ready, out_valid, result, c_out, eq,
    output alu_a, alu_b, alu_s, alu_m, alu_c_in
  );
  modport master (
    output in_valid, op_a, op_b, op_s, op_m, op_c_in, out_ready,
    output alu_f, alu_c_out, alu_a_eq_b,
    input  in_ready, out_valid, result, c_out, eq,
    input  alu_a, alu_b, alu_s, alu_m, alu_c_in
  );
`endif
endinterface

// File: rtl/ula_nibble_sequencer.sv
// ula_nibble_sequencer: runs a WIDTH-bit operation through one external 4-bit
// ula_74181, one nibble per clock with the LSB nibble first. Carry and equality
// are chained from nibble to nibble. The assembled result is returned over a
// valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature: define ULA_SEQ_ZERO_FLAG_EN to add a registered zero flag.
// The flag is built from a running OR of the ALU slices, so there is no
// full-width compare.
module ula_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ula_nibble_sequencer_if.slave  bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;      // carry/borrow into the current nibble
  logic             eq_acc_q, eq_acc_d;    // AND of a_eq_b over the nibbles done so far
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             eq_q, eq_d;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic             zero_acc_q, zero_acc_d; // OR of every F slice seen so far
  logic             zero_q, zero_d;
`endif

  logic [3:0] alu_a, alu_b, alu_s;
  logic       alu_m, alu_c_in;
  logic       last_nibble;
  logic       any_f_bit;

  // Latched operands split into nibble lanes so RUN can pick a lane by cnt
  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));
  assign any_f_bit   = |bus.alu_f;

  // State register and all datapath registers, with a synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      carry_q    <= 1'b0;
      eq_acc_q   <= 1'b1;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      eq_q       <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      zero_acc_q <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      m_q        <= m_d;
      carry_q    <= carry_d;
      eq_acc_q   <= eq_acc_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      eq_q       <= eq_d;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      zero_acc_q <= zero_acc_d;
      zero_q     <= zero_d;
`endif
    end
  end

  // Next-state logic, per-nibble accumulation and the ALU slice drive
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    m_d        = m_q;
    carry_d    = carry_q;
    eq_acc_d   = eq_acc_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    eq_d       = eq_q;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    zero_acc_d = zero_acc_q;
    zero_d     = zero_q;
`endif
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_s      = 4'h0;
    alu_m      = 1'b0;
    alu_c_in   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.op_a;
          b_d        = bus.op_b;
          s_d        = bus.op_s;
          m_d        = bus.op_m;
          carry_d    = bus.op_c_in;
          eq_acc_d   = 1'b1;
          cnt_d      = '0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
          zero_acc_d = 1'b0;
`endif
          state_d    = RUN;
        end
      end

      RUN: begin
        // The ALU sees nothing while reset is held, even if state is still RUN
        if (!rst) begin
          alu_a    = a_nib[cnt_q];
          alu_b    = b_nib[cnt_q];
          alu_s    = s_q;
          alu_m    = m_q;
          alu_c_in = carry_q;
        end
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            result_d[4*i +: 4] = bus.alu_f;
          end
        end
        carry_d    = bus.alu_c_out;
        eq_acc_d   = eq_acc_q & bus.alu_a_eq_b;
        cnt_d      = cnt_q + CNT_W'(1);
`ifdef ULA_SEQ_ZERO_FLAG_EN
        zero_acc_d = zero_acc_q | any_f_bit;
`endif
        if (last_nibble) begin
          // The flags take the values that carry/eq_acc receive on this edge
          c_out_d = bus.alu_c_out;
          eq_d    = eq_acc_q & bus.alu_a_eq_b;
          cnt_d   = '0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
          zero_d  = ~(zero_acc_q | any_f_bit);
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.c_out     = c_out_q;
  assign bus.eq        = eq_q;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`endif
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_s     = alu_s;
  assign bus.alu_m     = alu_m;
  assign bus.alu_c_in  = alu_c_in;

  // any_f_bit only feeds the zero flag
  logic unused_any_f;
  assign unused_any_f = any_f_bit;

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// Testbench for ula_nibble_sequencer (WIDTH=16) with a small behavioural
// ula_74181 attached to the ALU slice link. Expected results are hand-computed
// constants pushed into a scoreboard when each request is issued. A monitor
// pops an entry and compares it whenever a result handshake occurs.
// Checks the zero flag too when ULA_SEQ_ZERO_FLAG_EN is defined.
module tb_ula_nibble_sequencer;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  ula_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 4-bit ALU slice covering the functions used below
  logic [4:0] alu_tmp;
  always_comb begin
    alu_tmp        = 5'd0;
    bus.alu_f      = bus.alu_a;
    bus.alu_c_out  = 1'b0;
    bus.alu_a_eq_b = (bus.alu_a == bus.alu_b);
    case ({bus.alu_m, bus.alu_s})
      5'b0_1001: begin  // A plus B plus carry
        alu_tmp       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_c_in};
        bus.alu_f     = alu_tmp[3:0];
        bus.alu_c_out = alu_tmp[4];
      end
      5'b0_0110: begin  // A minus B minus borrow
        alu_tmp       = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'd0, bus.alu_c_in};
        bus.alu_f     = alu_tmp[3:0];
        bus.alu_c_out = alu_tmp[4];
      end
      5'b1_0110: bus.alu_f = bus.alu_a ^ bus.alu_b;
      5'b1_1011: bus.alu_f = bus.alu_a & bus.alu_b;
      5'b1_1110: bus.alu_f = bus.alu_a | bus.alu_b;
      default:   bus.alu_f = bus.alu_a;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             e;
    logic             z;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handshake pops one expectation and compares it
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("c_out", 32'(bus.c_out), 32'(e.c));
        check("eq", 32'(bus.eq), 32'(e.e));
`ifdef ULA_SEQ_ZERO_FLAG_EN
        check("zero", 32'(bus.zero), 32'(e.z));
`endif
        $display("result %h c_out %b eq %b", bus.result, bus.c_out, bus.eq);
      end
    end
  end

  // Issue one operation, check the first ALU slice and the latency, optionally
  // stall in DONE, then take the result with a one-cycle out_ready.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] s, input logic m, input logic cin,
                        input logic [WIDTH-1:0] res, input logic c, input logic e,
                        input logic z, input int hold);
    exp_t ex;
    int   k;
    bit   got;
    @(posedge clk); #1;
    bus.op_a = a; bus.op_b = b; bus.op_s = s; bus.op_m = m; bus.op_c_in = cin;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1'b1; break; end
    end
    check("in_ready_wait", 32'(got), 32'(1));
    if (!got) begin bus.in_valid = 1'b0; return; end
    @(posedge clk); #1;  // accepting edge
    ex.res = res; ex.c = c; ex.e = e; ex.z = z;
    sb_q.push_back(ex);
    $display("issue a=%h b=%h s=%b m=%b c_in=%b", a, b, s, m, cin);
    // Operand changes after acceptance must have no effect
    bus.in_valid = 1'b0;
    bus.op_a = ~a; bus.op_b = a; bus.op_s = ~s; bus.op_m = ~m; bus.op_c_in = ~cin;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("alu_first_slice", {20'd0, bus.alu_a, bus.alu_b, bus.alu_s},
              {20'd0, a[3:0], b[3:0], s});
        check("alu_first_mc", {30'd0, bus.alu_m, bus.alu_c_in}, {30'd0, m, cin});
      end
      if (bus.out_valid) break;
      k++;
    end
    check("latency", 32'(k), 32'(4));
    if (!bus.out_valid) begin void'(sb_q.pop_back()); return; end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = h[0];
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'(1));
      check("hold_result", 32'(bus.result), 32'(res));
      check("hold_in_ready", 32'(bus.in_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;  // handshake edge
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("valid_fall", 32'(bus.out_valid), 32'(0));
    check("idle_in_ready", 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.op_s = '0; bus.op_m = 1'b0; bus.op_c_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_alu", {19'd0, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m},
          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("reset_result", 32'(bus.result), 32'(0));
    check("reset_flags", {30'd0, bus.c_out, bus.eq}, 32'd0);
`ifdef ULA_SEQ_ZERO_FLAG_EN
    check("reset_zero", 32'(bus.zero), 32'(0));
`endif
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));
    check("idle_alu", {27'd0, bus.alu_a, bus.alu_c_in}, 32'd0);

    // Directed vectors: a, b, s, m, c_in -> result, c_out, eq, zero, stall cycles
    run_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h1234, 4'b1001, 1'b0, 1'b0, 16'h2468, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 0);
    // Stall in DONE for 5 cycles with in_valid pulses
    run_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 5);

    // Reset in the second RUN cycle aborts the operation
    @(posedge clk); #1;
    bus.op_a = 16'hFFFF; bus.op_b = 16'h0001; bus.op_s = 4'b1001;
    bus.op_m = 1'b0; bus.op_c_in = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;  // accepting edge
    bus.in_valid = 1'b0;
    @(posedge clk); #1;  // now in the second RUN cycle
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(bus.in_ready), 32'(0));
    check("abort_alu", {27'd0, bus.alu_a, bus.alu_c_in}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_out_valid", 32'(bus.out_valid), 32'(0));
      if (i == 0) begin
        check("abort_in_ready_after", 32'(bus.in_ready), 32'(1));
        check("abort_result", 32'(bus.result), 32'(0));
      end
    end
    $display("abort done");
    run_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
